mpu_feed_sequencer: RTL and testbench

- Controller for the MPU row-buffer bank: ROWS instances of the team's `buffer` FIFO, one per systolic-array row.
- Load phase: accepts a column-major int8 operand stream and steers each beat into the FIFO of its row.
- Feed phase: drains the FIFOs into the array with the diagonal skew the array needs (row i starts i cycles after row 0).
- Sits between the operand DMA stream and the array's west edge; owns every FIFO wen/ren.

---
 rtl/mpu_pkg.sv | 15 +
 rtl/mpu_skew_window.sv | 27 ++
 rtl/mpu_feed_sequencer.sv | 165 ++++++++++++++++
 tb/tb_mpu_feed_sequencer.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared types and default geometry for the MPU row-buffer bank.
package mpu_pkg;

  localparam int ROWS_DEF  = 4;
  localparam int ASIZE_DEF = 3;
  localparam int DSIZE_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FEED = 2'd2,
    DONE = 2'd3
  } mpu_seq_state_e;

endpackage

// File: rtl/mpu_skew_window.sv
// Diagonal feed window: row i is wanted while t lies in [i, i+len).
// Comparisons are made one bit wider than t so i+len never wraps.
module mpu_skew_window
  import mpu_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int TW    = $clog2(2**ASIZE_DEF + ROWS_DEF)
) (
  input  logic [TW-1:0]  t,
  input  logic [ASIZE:0] len,
  output logic [ROWS-1:0] want
);

  logic [TW:0] t_x_s;
  logic [TW:0] len_x_s;

  // Evaluate each row's window against the shared feed cycle counter.
  always_comb begin
    t_x_s   = {1'b0, t};
    len_x_s = (TW+1)'(len);
    for (int i = 0; i < ROWS; i++) begin
      want[i] = (t_x_s >= (TW+1)'(i)) && (t_x_s < ((TW+1)'(i) + len_x_s));
    end
  end

endmodule

// File: rtl/mpu_feed_sequencer.sv
// Row-buffer bank controller: steers a column-major operand stream into
// per-row FIFOs, then drains them into the array with a one-cycle-per-row skew.
module mpu_feed_sequencer
  import mpu_pkg::*;
#(
  parameter int ROWS  = ROWS_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int DSIZE = DSIZE_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [ASIZE:0]   cfg_len,
  output logic             busy,
  output logic             done,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DSIZE-1:0] in_data,
  input  logic             feed_stall,
  input  logic [ROWS-1:0]  fifo_full,
  input  logic [ROWS-1:0]  fifo_empty,
  output logic [ROWS-1:0]  fifo_wen,
  output logic [DSIZE-1:0] fifo_din,
  output logic [ROWS-1:0]  fifo_ren
);

  localparam int TW = $clog2(2**ASIZE + ROWS);
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ASIZE:0] DEPTH    = (ASIZE+1)'(2**ASIZE);
  localparam logic [RW-1:0]  LAST_ROW = RW'(ROWS-1);

  mpu_seq_state_e    state_r;
  logic [ASIZE:0]    len_r;
  logic [RW-1:0]     row_ptr_r;
  logic [ASIZE:0]    col_r;
  logic [TW-1:0]     t_r;
  logic              busy_r;
  logic              done_r;

  logic [ROWS-1:0]   want_s;
  logic              ready_s;
  logic              hs_s;
  logic              go_s;
  logic              feed_last_s;

  mpu_skew_window #(
    .ROWS  (ROWS),
    .ASIZE (ASIZE),
    .TW    (TW)
  ) u_skew (
    .t    (t_r),
    .len  (len_r),
    .want (want_s)
  );

  assign busy     = busy_r;
  assign done     = done_r;
  assign in_ready = ready_s;
  assign fifo_din = in_data;

  // Stream handshake, FIFO strobes and feed advance for the current state.
  always_comb begin
    ready_s     = 1'b0;
    hs_s        = 1'b0;
    go_s        = 1'b0;
    fifo_wen    = {ROWS{1'b0}};
    fifo_ren    = {ROWS{1'b0}};
    feed_last_s = (({1'b0, t_r} + (TW+1)'(1)) ==
                   ((TW+1)'(len_r) + (TW+1)'(ROWS-1)));
    case (state_r)
      LOAD: begin
        ready_s = ~fifo_full[row_ptr_r];
        hs_s    = in_valid & ready_s;
        if (hs_s) begin
          fifo_wen[row_ptr_r] = 1'b1;
        end else begin
          fifo_wen = {ROWS{1'b0}};
        end
      end
      FEED: begin
        go_s = ~feed_stall & ~|(want_s & fifo_empty);
        if (go_s) begin
          fifo_ren = want_s;
        end else begin
          fifo_ren = {ROWS{1'b0}};
        end
      end
      IDLE, DONE: begin
        ready_s = 1'b0;
      end
      default: begin
        ready_s = 1'b0;
      end
    endcase
  end

  // Job FSM with counters; busy/done are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r   <= IDLE;
      len_r     <= {(ASIZE+1){1'b0}};
      row_ptr_r <= {RW{1'b0}};
      col_r     <= {(ASIZE+1){1'b0}};
      t_r       <= {TW{1'b0}};
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            len_r     <= cfg_len;
            row_ptr_r <= {RW{1'b0}};
            col_r     <= {(ASIZE+1){1'b0}};
            t_r       <= {TW{1'b0}};
            if ((cfg_len != {(ASIZE+1){1'b0}}) && (cfg_len <= DEPTH)) begin
              state_r <= LOAD;
              busy_r  <= 1'b1;
            end else begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (hs_s) begin
            if (row_ptr_r == LAST_ROW) begin
              row_ptr_r <= {RW{1'b0}};
              col_r     <= col_r + (ASIZE+1)'(1);
              if (col_r == (len_r - (ASIZE+1)'(1))) begin
                state_r <= FEED;
                t_r     <= {TW{1'b0}};
              end
            end else begin
              row_ptr_r <= row_ptr_r + RW'(1);
            end
          end
        end
        FEED: begin
          if (go_s) begin
            if (feed_last_s) begin
              state_r <= DONE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              t_r <= t_r + TW'(1);
            end
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mpu_feed_sequencer.sv
// Scoreboard bench for mpu_feed_sequencer with behavioural row FIFOs.
module tb_mpu_feed_sequencer;

  localparam int ROWS  = 4;
  localparam int ASIZE = 3;
  localparam int DSIZE = 8;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [ASIZE:0]   cfg_len = 4'd0;
  logic             busy, done;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [DSIZE-1:0] in_data = 8'd0;
  logic             feed_stall = 1'b0;
  logic [ROWS-1:0]  fifo_full, fifo_empty, fifo_wen, fifo_ren;
  logic [DSIZE-1:0] fifo_din;

  logic [ROWS-1:0]  full_m = 4'b0000;
  logic [ROWS-1:0]  empty_m = 4'b1111;
  logic [ROWS-1:0]  force_full = 4'b0000;
  logic [ROWS-1:0]  force_empty = 4'b0000;
  assign fifo_full  = full_m | force_full;
  assign fifo_empty = empty_m | force_empty;

  always #5 clk = ~clk;

  mpu_feed_sequencer #(.ROWS(ROWS), .ASIZE(ASIZE), .DSIZE(DSIZE)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .feed_stall(feed_stall), .fifo_full(fifo_full),
    .fifo_empty(fifo_empty), .fifo_wen(fifo_wen), .fifo_din(fifo_din),
    .fifo_ren(fifo_ren)
  );

  int n_checks = 0;
  int n_fail = 0;

  // Job context published by the stimulus, read by the monitor.
  bit job_active = 1'b0;
  bit job_valid  = 1'b0;
  int job_len    = 0;
  int done_count = 0;

  // Monitor-owned progress counters.
  int wen_cnt = 0;
  int adv_k = 0;
  int since_start = 0;

  // Scoreboard queues and FIFO model contents.
  logic [DSIZE-1:0] exp_wr_q[$];
  logic [DSIZE-1:0] exp_rd_q[ROWS][$];
  logic [DSIZE-1:0] fq[ROWS][$];

  logic             cap_rst = 1'b0;
  logic [ROWS-1:0]  cap_wen = 4'b0000;
  logic [ROWS-1:0]  cap_ren = 4'b0000;
  logic [DSIZE-1:0] cap_din = 8'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Row FIFO model: commits the strobes captured before each edge.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < ROWS; i++) begin
      if (!cap_rst) begin
        fq[i].delete();
      end else begin
        if (cap_ren[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        if (cap_wen[i]) fq[i].push_back(cap_din);
      end
      full_m[i]  = (fq[i].size() >= DEPTH);
      empty_m[i] = (fq[i].size() == 0);
    end
  end

  // Monitor: compares DUT outputs against the job-level reference each cycle.
  always @(negedge clk) begin
    int beats, tot, row;
    bit in_load, in_feed, exp_ready, exp_done, blocked;
    logic [ROWS-1:0] want_b, exp_ren, exp_wen;
    cap_rst = rst; cap_wen = fifo_wen; cap_ren = fifo_ren; cap_din = fifo_din;
    if (!rst) begin
      exp_wr_q.delete();
      for (int i = 0; i < ROWS; i++) exp_rd_q[i].delete();
      wen_cnt = 0; adv_k = 0;
    end else if (!job_active) begin
      chk("idle_outputs", 32'({busy, done, in_ready, fifo_wen, fifo_ren}), 32'd0);
      if (start) begin
        wen_cnt = 0; adv_k = 0; since_start = 0;
      end
    end else begin
      since_start++;
      beats    = job_valid ? ROWS * job_len : 0;
      tot      = job_valid ? job_len + ROWS - 1 : 0;
      in_load  = job_valid && (wen_cnt < beats);
      in_feed  = job_valid && !in_load && (adv_k < tot);
      exp_done = job_valid ? (!in_load && adv_k == tot) : (since_start == 1);
      row      = wen_cnt % ROWS;
      exp_ready = in_load && !fifo_full[row];
      exp_wen  = (exp_ready && in_valid) ? (4'b0001 << row) : 4'b0000;
      for (int i = 0; i < ROWS; i++)
        want_b[i] = in_feed && (adv_k >= i) && (adv_k < i + job_len);
      blocked  = feed_stall || ((want_b & fifo_empty) != 4'b0000);
      exp_ren  = blocked ? 4'b0000 : want_b;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("fifo_wen", 32'(fifo_wen), 32'(exp_wen));
      chk("fifo_ren", 32'(fifo_ren), 32'(exp_ren));
      chk("done", 32'(done), 32'(exp_done));
      chk("busy", 32'(busy), 32'(job_valid && !exp_done));
      if (exp_wen != 4'b0000) begin
        if (exp_wr_q.size() == 0) chk("wr_underrun", 32'd1, 32'd0);
        else chk("fifo_din", 32'(fifo_din), 32'(exp_wr_q.pop_front()));
        wen_cnt++;
      end
      for (int i = 0; i < ROWS; i++) begin
        if (fifo_ren[i]) begin
          if (fq[i].size() == 0 || exp_rd_q[i].size() == 0) chk("rd_underrun", 32'd1, 32'd0);
          else chk("row_data", 32'(fq[i][0]), 32'(exp_rd_q[i].pop_front()));
        end
      end
      if (exp_ren != 4'b0000) adv_k++;
      if (exp_done && job_valid) begin
        for (int i = 0; i < ROWS; i++) chk("row_drained", 32'(exp_rd_q[i].size()), 32'd0);
        chk("beats_accepted", 32'(wen_cnt), 32'(beats));
      end
      if (done) done_count++;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // stall_mode: 0 none, 1 random, 2 three cycles at t=2.
  task automatic run_job(input int len, input int stall_mode, input bit seq_data,
                         input bit bp_test, input bit eg_test, input bit abort_test,
                         input bit restart_test);
    int beats, dc0, guard;
    bit valid, hs, aborted;
    logic [DSIZE-1:0] d;
    valid = (len >= 1) && (len <= DEPTH);
    beats = valid ? ROWS * len : 0;
    dc0 = done_count;
    aborted = 1'b0;
    cfg_len = (ASIZE+1)'(len);
    start = 1'b1;
    step();
    start = 1'b0;
    cfg_len = (ASIZE+1)'($urandom_range(0, 15));
    job_len = len; job_valid = valid; job_active = 1'b1;
    for (int j = 0; j < beats; j++) begin
      d = seq_data ? DSIZE'(j) : DSIZE'($urandom);
      exp_wr_q.push_back(d);
      exp_rd_q[j % ROWS].push_back(d);
      if (!seq_data) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0; in_data = DSIZE'($urandom); step();
        end
      end
      in_valid = 1'b1; in_data = d;
      if (restart_test && j == 1) begin
        start = 1'b1; cfg_len = 4'd5;
      end
      if (bp_test && j == 2) begin
        force_full = 4'b0100;
        repeat (3) step();
        force_full = 4'b0000;
      end
      guard = 0;
      do begin
        @(negedge clk);
        hs = in_valid && in_ready;
        step();
        start = 1'b0;
        guard++;
      end while (!hs && guard < 100);
      if (!hs) chk("load_timeout", 32'd1, 32'd0);
    end
    in_valid = 1'b0;
    guard = 0;
    while (done_count == dc0 && guard < 400 && !aborted) begin
      case (stall_mode)
        1: feed_stall = ($urandom_range(0, 99) < 30);
        2: feed_stall = (guard >= 2 && guard <= 4);
        default: feed_stall = 1'b0;
      endcase
      force_empty = (eg_test && guard >= 3 && guard <= 5) ? 4'b1000 : 4'b0000;
      if (abort_test && guard == 3) begin
        feed_stall = 1'b0;
        rst = 1'b0; job_active = 1'b0;
        step(); step();
        rst = 1'b1;
        aborted = 1'b1;
      end
      step();
      guard++;
    end
    feed_stall = 1'b0; force_empty = 4'b0000;
    if (!aborted && done_count == dc0) begin
      chk("done_timeout", 32'd1, 32'd0);
      rst = 1'b0; job_active = 1'b0; step(); rst = 1'b1;
    end
    job_active = 1'b0;
    step();
  endtask

  initial begin
    repeat (3) step();
    rst = 1'b1;
    step(); step();
    run_job(3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // nominal, values 0..11
    run_job(3, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);   // load back-pressure on row 2
    run_job(3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // directed feed stall
    run_job(2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // empty guard on row 3
    run_job(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // zero length
    run_job(12, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);  // over depth
    run_job(8, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // full depth
    run_job(4, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // start while busy
    run_job(4, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // reset mid-feed
    for (int n = 0; n < 6; n++)
      run_job($urandom_range(1, 8), 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
